temp_sensor_frontend: RTL and testbench

//  Upstream stage of Smart_Home. Periodically reads an 8-bit unsigned degC value from a
//  3-wire serial thermometer (cs_n/sclk/sdo) and filters it with a 2^AVG_LOG2-tap moving average.
//  It then saturates the result to 5 bits and drives Smart_Home's temperature[4:0] input.
//  It also flags sensor faults so the controller can ignore stale data.

---
 rtl/smart_home_pkg.sv | 22 ++
 rtl/moving_avg_filter.sv | 57 +++++
 rtl/temp_sensor_frontend.sv | 160 ++++++++++++++++
 tb/tb_temp_sensor_frontend.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/smart_home_pkg.sv
// Shared definitions between the temperature front end and the Smart_Home controller.
package smart_home_pkg;

   localparam int                TEMP_W       = 5;
   localparam logic [TEMP_W-1:0] TEMP_MAX     = 5'd31;
   localparam logic [7:0]        SENSOR_FAULT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SHIFT = 2'd2,
      STOP  = 2'd3
   } sen_state_e;

   // Clamp an 8-bit average into the controller's 5-bit temperature range.
   function automatic logic [TEMP_W-1:0] sat_temp(input logic [7:0] avg);
      logic [7:0] lim;
      lim = {{(8-TEMP_W){1'b0}}, TEMP_MAX};
      return (avg > lim) ? TEMP_MAX : avg[TEMP_W-1:0];
   endfunction

endpackage

// File: rtl/moving_avg_filter.sv
// 2^AVG_LOG2-tap moving average with a running sum; prime loads every tap at once.
module moving_avg_filter
   import smart_home_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       prime,
   output logic       out_valid,
   output logic [7:0] out_avg
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = 8 + AVG_LOG2;

   logic [7:0]       taps_q [DEPTH];
   logic [7:0]       taps_d [DEPTH];
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             valid_q, valid_d;

   // Next tap history and running sum: prime fills all taps, otherwise drop the oldest.
   always_comb begin
      taps_d  = taps_q;
      sum_d   = sum_q;
      valid_d = in_valid;
      if (in_valid) begin
         if (prime) begin
            for (int i = 0; i < DEPTH; i++) taps_d[i] = in_data;
            sum_d = SUM_W'(in_data) << AVG_LOG2;
         end else begin
            taps_d[0] = in_data;
            for (int i = 1; i < DEPTH; i++) taps_d[i] = taps_q[i-1];
            sum_d = sum_q + SUM_W'(in_data) - SUM_W'(taps_q[DEPTH-1]);
         end
      end
   end

   // History, sum and valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         taps_q  <= taps_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_avg   = 8'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/temp_sensor_frontend.sv
// Serial thermometer reader: periodic conversion, fault flagging, averaging, saturation.
//
//  state | meaning
//  IDLE  | cs_n high, waiting for the period tick
//  START | cs_n low, sclk low for CLK_DIV cycles before the first bit
//  SHIFT | 8 bits, each CLK_DIV low then CLK_DIV high; sdo sampled as sclk rises
//  STOP  | last cs_n-low cycle; raw byte checked and pushed to the filter
module temp_sensor_frontend
   import smart_home_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000,
   parameter int AVG_LOG2      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sen_sdo,
   output logic              sen_cs_n,
   output logic              sen_sclk,
   output logic [TEMP_W-1:0] temperature,
   output logic              temp_valid,
   output logic              sensor_err
);

   localparam int PER_W = $clog2(SAMPLE_PERIOD);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] TMR_LOAD = DIV_W'(CLK_DIV - 1);

   sen_state_e        state_q, state_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic [DIV_W-1:0]  tmr_q, tmr_d;
   logic              half_q, half_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              primed_q, primed_d;
   logic              err_q, err_d;
   logic [TEMP_W-1:0] temp_q, temp_d;
   logic              tvalid_q, tvalid_d;

   logic              tick;
   logic              flt_push;
   logic              flt_valid;
   logic [7:0]        flt_avg;

   // Free-running period counter; conversion start at its terminal value.
   always_comb begin
      tick  = (per_q == PER_W'(SAMPLE_PERIOD - 1));
      per_d = tick ? '0 : per_q + PER_W'(1);
   end

   // Serial conversion FSM, sclk phase timer and shift register.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      half_d   = half_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      primed_d = primed_q;
      err_d    = err_q;
      flt_push = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = START;
               tmr_d   = TMR_LOAD;
            end
         end
         START: begin
            if (tmr_q == '0) begin
               state_d = SHIFT;
               tmr_d   = TMR_LOAD;
               half_d  = 1'b0;
               bit_d   = 3'd0;
            end else begin
               tmr_d = tmr_q - DIV_W'(1);
            end
         end
         SHIFT: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - DIV_W'(1);
            end else if (!half_q) begin
               // sclk rises on this edge: capture the bit the sensor is presenting.
               half_d  = 1'b1;
               tmr_d   = TMR_LOAD;
               shreg_d = {shreg_q[6:0], sen_sdo};
            end else if (bit_q == 3'd7) begin
               state_d = STOP;
               half_d  = 1'b0;
            end else begin
               half_d = 1'b0;
               tmr_d  = TMR_LOAD;
               bit_d  = bit_q + 3'd1;
            end
         end
         STOP: begin
            state_d = IDLE;
            if (shreg_q == SENSOR_FAULT) begin
               err_d = 1'b1;
            end else begin
               err_d    = 1'b0;
               flt_push = 1'b1;
               primed_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   moving_avg_filter #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (flt_push),
      .in_data   (shreg_q),
      .prime     (!primed_q),
      .out_valid (flt_valid),
      .out_avg   (flt_avg)
   );

   // Saturated output register; holds across faults and idle periods.
   always_comb begin
      tvalid_d = flt_valid;
      temp_d   = flt_valid ? sat_temp(flt_avg) : temp_q;
   end

   // All front-end state; reset aborts any conversion in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         per_q    <= '0;
         tmr_q    <= '0;
         half_q   <= 1'b0;
         bit_q    <= 3'd0;
         shreg_q  <= 8'd0;
         primed_q <= 1'b0;
         err_q    <= 1'b0;
         temp_q   <= '0;
         tvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         tmr_q    <= tmr_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         primed_q <= primed_d;
         err_q    <= err_d;
         temp_q   <= temp_d;
         tvalid_q <= tvalid_d;
      end
   end

   assign sen_cs_n    = (state_q == IDLE);
   assign sen_sclk    = (state_q == SHIFT) && half_q;
   assign temperature = temp_q;
   assign temp_valid  = tvalid_q;
   assign sensor_err  = err_q;

endmodule

// File: tb/tb_temp_sensor_frontend.sv
// Directed bench: a modelled serial thermometer returns programmed bytes.
module tb_temp_sensor_frontend;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sen_sdo;
   logic       sen_cs_n;
   logic       sen_sclk;
   logic [4:0] temperature;
   logic       temp_valid;
   logic       sensor_err;

   logic [7:0] sen_byte = 8'd0;
   int         sen_idx  = 0;
   int         vectors  = 0;
   int         errors   = 0;

   temp_sensor_frontend #(
      .CLK_DIV       (2),
      .SAMPLE_PERIOD (64),
      .AVG_LOG2      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sen_sdo     (sen_sdo),
      .sen_cs_n    (sen_cs_n),
      .sen_sclk    (sen_sclk),
      .temperature (temperature),
      .temp_valid  (temp_valid),
      .sensor_err  (sensor_err)
   );

   always #5 clk = ~clk;

   // Sensor model: MSB presented at cs_n fall, next bit after each sclk fall.
   always @(negedge sen_cs_n) sen_idx = 0;
   always @(negedge sen_sclk) if (!sen_cs_n) sen_idx = sen_idx + 1;
   assign sen_sdo = (sen_idx < 8) ? sen_byte[7 - sen_idx] : 1'b1;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full conversion: bounded wait for cs_n, measure frame, check result.
   task automatic do_conv(input logic [7:0] b, input int exp_wait, input int exp_t,
                          input int exp_v, input int exp_e, input string tag);
      int n, low, rises, vmid;
      logic prev;
      sen_byte = b;
      n = 0;
      while (sen_cs_n && n < 200) begin
         cyc();
         n++;
      end
      check({tag, " start_delay"}, n, exp_wait);
      low = 0; rises = 0; vmid = 0;
      while (!sen_cs_n && low < 100) begin
         prev = sen_sclk;
         cyc();
         low++;
         if (!prev && sen_sclk) rises++;
         if (temp_valid) vmid++;
      end
      check({tag, " cs_low_cycles"}, low, 35);
      check({tag, " sclk_rises"}, rises, 8);
      check({tag, " valid_in_frame"}, vmid, 0);
      check({tag, " sclk_idle"}, int'(sen_sclk), 0);
      cyc();
      check({tag, " temp_valid"}, int'(temp_valid), exp_v);
      check({tag, " temperature"}, int'(temperature), exp_t);
      check({tag, " sensor_err"}, int'(sensor_err), exp_e);
      cyc();
      check({tag, " valid_pulse_end"}, int'(temp_valid), 0);
   endtask

   initial begin
      // Reset held for three cycles.
      rst = 1'b1;
      cyc(); cyc(); cyc();
      check("rst cs_n", int'(sen_cs_n), 1);
      check("rst sclk", int'(sen_sclk), 0);
      check("rst temperature", int'(temperature), 0);
      check("rst temp_valid", int'(temp_valid), 0);
      check("rst sensor_err", int'(sensor_err), 0);
      rst = 1'b0;

      do_conv(8'd22, 64, 22, 1, 0, "first22");

      // Fresh reset, prime at 20, then truncating ramp toward 24.
      rst = 1'b1;
      cyc(); cyc(); cyc();
      rst = 1'b0;
      do_conv(8'd20, 64, 20, 1, 0, "prime20");
      do_conv(8'd24, 27, 21, 1, 0, "avg24a");
      do_conv(8'd24, 27, 22, 1, 0, "avg24b");
      do_conv(8'd24, 27, 23, 1, 0, "avg24c");
      do_conv(8'd24, 27, 24, 1, 0, "avg24d");

      // Open-line fault, then recovery that still averages the history.
      do_conv(8'hFF, 27, 24, 0, 1, "fault");
      do_conv(8'd18, 27, 22, 1, 0, "recover18");

      // Saturation: averages 31, 40, 49, 60 all clamp to 31.
      do_conv(8'd60, 27, 31, 1, 0, "sat60a");
      do_conv(8'd60, 27, 31, 1, 0, "sat60b");
      do_conv(8'd60, 27, 31, 1, 0, "sat60c");
      do_conv(8'd60, 27, 31, 1, 0, "sat60d");

      // Reset in the middle of SHIFT aborts the frame and clears history.
      sen_byte = 8'd200;
      begin
         int n;
         n = 0;
         while (sen_cs_n && n < 200) begin
            cyc();
            n++;
         end
         check("midrst start_delay", n, 27);
      end
      repeat (10) cyc();
      check("midrst in_shift", int'(sen_cs_n), 0);
      rst = 1'b1;
      cyc();
      check("midrst cs_n", int'(sen_cs_n), 1);
      check("midrst sclk", int'(sen_sclk), 0);
      check("midrst temp_valid", int'(temp_valid), 0);
      check("midrst temperature", int'(temperature), 0);
      rst = 1'b0;
      do_conv(8'd10, 64, 10, 1, 0, "reprime10");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
